// File: rtl/bats_pkg.sv
// Shared definitions for the BATS PITCH UDP payload packer.
// Holds the packed word geometry and the frame-tracking FSM state type.
package bats_pkg;

  localparam int unsigned WordWidth = 64;
  localparam int unsigned Lanes     = 8;
  // Wide enough to count lanes 0..Lanes.
  localparam int unsigned CntWidth  = $clog2(Lanes + 1);

  typedef enum logic [0:0] {
    StInHdr,
    StInBody
  } frame_state_e;

endpackage

// File: rtl/udp_payload_packer.sv
// Packs a byte stream of UDP payload (BATS PITCH frames) into 64-bit words for the parser.
// Byte k of a word lands in out_bytes[63-8k:56-8k] with enable bit 7-k set; a word is emitted
// after 8 bytes or on the frame's last byte. Also tracks frame length from the 2-byte
// little-endian header and counts frames and length mismatches.
//
// Ports:
//   Clk40, reset           clock, synchronous active-high reset
//   in_byte/in_valid/in_last/in_ready   byte input stream with handshake
//   out_bytes/out_byte_enables/out_data_valid/out_ready   word output with handshake
//   frame_count            completed frames (wraps)
//   len_err_count          length mismatches (saturates)
//   len_err                one-cycle pulse per length mismatch
module udp_payload_packer
  import bats_pkg::*;
(
  input  logic                 Clk40,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WordWidth-1:0] out_bytes,
  output logic [Lanes-1:0]     out_byte_enables,
  output logic                 out_data_valid,
  input  logic                 out_ready,
  output logic [31:0]          frame_count,
  output logic [15:0]          len_err_count,
  output logic                 len_err
);

  // Accumulator: collects bytes; acc_done_q marks a completed word waiting for the output reg.
  logic [WordWidth-1:0] acc_data_q, acc_data_d;
  logic [Lanes-1:0]     acc_en_q, acc_en_d;
  logic [CntWidth-1:0]  acc_cnt_q, acc_cnt_d;
  logic                 acc_done_q, acc_done_d;

  // Output register.
  logic [WordWidth-1:0] out_data_q, out_data_d;
  logic [Lanes-1:0]     out_en_q, out_en_d;
  logic                 out_valid_q, out_valid_d;

  // Frame tracking.
  frame_state_e state_q, state_d;
  logic [15:0]  hdr_len_q, hdr_len_d;
  logic [15:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0]  frame_count_q, frame_count_d;
  logic [15:0]  len_err_count_q, len_err_count_d;
  logic         len_err_q;

  logic                 out_free;
  logic                 in_ready_c;
  logic                 accept;
  logic                 drain;
  logic                 complete;
  logic [WordWidth-1:0] base_data, merged_data;
  logic [Lanes-1:0]     base_en, merged_en;
  logic [CntWidth-1:0]  base_cnt;
  logic [15:0]          frame_len;
  logic [15:0]          frame_total;
  logic                 mismatch;

  // Datapath: accumulator and output register next state.
  always_comb begin
    out_free   = !out_valid_q || out_ready;
    in_ready_c = !reset && !(acc_done_q && !out_free);
    accept     = in_valid && in_ready_c;
    // A completed word moves into the output register as soon as it frees up.
    drain      = acc_done_q && out_free;

    base_data = drain ? '0 : acc_data_q;
    base_en   = drain ? '0 : acc_en_q;
    base_cnt  = drain ? '0 : acc_cnt_q;

    merged_data = base_data;
    merged_en   = base_en;
    for (int unsigned l = 0; l < Lanes; l++) begin
      if (CntWidth'(l) == base_cnt) begin
        merged_data[8*(Lanes-1-l) +: 8] = in_byte;
        merged_en[Lanes-1-l]            = 1'b1;
      end
    end

    complete = accept && (in_last || (base_cnt == CntWidth'(Lanes - 1)));

    acc_data_d  = acc_data_q;
    acc_en_d    = acc_en_q;
    acc_cnt_d   = acc_cnt_q;
    acc_done_d  = acc_done_q;
    out_data_d  = out_data_q;
    out_en_d    = out_en_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (drain) begin
      out_data_d  = acc_data_q;
      out_en_d    = acc_en_q;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_en_d    = '0;
      acc_cnt_d   = '0;
      acc_done_d  = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        if (out_free && !drain) begin
          // Output slot free: completed word goes straight out (1-cycle latency).
          out_data_d  = merged_data;
          out_en_d    = merged_en;
          out_valid_d = 1'b1;
          acc_data_d  = '0;
          acc_en_d    = '0;
          acc_cnt_d   = '0;
          acc_done_d  = 1'b0;
        end else begin
          // Output busy: park the completed word in the accumulator.
          acc_data_d = merged_data;
          acc_en_d   = merged_en;
          acc_cnt_d  = '0;
          acc_done_d = 1'b1;
        end
      end else begin
        acc_data_d = merged_data;
        acc_en_d   = merged_en;
        acc_cnt_d  = base_cnt + CntWidth'(1);
        acc_done_d = 1'b0;
      end
    end
  end

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInHdr: begin
        if (accept && !in_last && (byte_cnt_q == 16'd1)) begin
          state_d = StInBody;
        end
      end
      StInBody: begin
        if (accept && in_last) begin
          state_d = StInHdr;
        end
      end
      default: state_d = StInHdr;
    endcase
  end

  // Length tracking and counters.
  always_comb begin
    hdr_len_d       = hdr_len_q;
    byte_cnt_d      = byte_cnt_q;
    frame_count_d   = frame_count_q;
    len_err_count_d = len_err_count_q;

    // When byte 1 is itself the last byte, the upper length byte is still on the bus.
    frame_len   = ((state_q == StInHdr) && (byte_cnt_q == 16'd1)) ?
                  {in_byte, hdr_len_q[7:0]} : hdr_len_q;
    frame_total = byte_cnt_q + 16'd1;
    mismatch    = accept && in_last &&
                  (((state_q == StInHdr) && (byte_cnt_q == 16'd0)) || (frame_total != frame_len));

    if (accept) begin
      if (state_q == StInHdr) begin
        if (byte_cnt_q == 16'd0) begin
          hdr_len_d[7:0] = in_byte;
        end else if (byte_cnt_q == 16'd1) begin
          hdr_len_d[15:8] = in_byte;
        end
      end
      if (in_last) begin
        byte_cnt_d    = '0;
        frame_count_d = frame_count_q + 32'd1;
      end else begin
        byte_cnt_d = frame_total;
      end
    end

    if (mismatch && (len_err_count_q != 16'hFFFF)) begin
      len_err_count_d = len_err_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      acc_data_q      <= '0;
      acc_en_q        <= '0;
      acc_cnt_q       <= '0;
      acc_done_q      <= 1'b0;
      out_data_q      <= '0;
      out_en_q        <= '0;
      out_valid_q     <= 1'b0;
      state_q         <= StInHdr;
      hdr_len_q       <= '0;
      byte_cnt_q      <= '0;
      frame_count_q   <= '0;
      len_err_count_q <= '0;
      len_err_q       <= 1'b0;
    end else begin
      acc_data_q      <= acc_data_d;
      acc_en_q        <= acc_en_d;
      acc_cnt_q       <= acc_cnt_d;
      acc_done_q      <= acc_done_d;
      out_data_q      <= out_data_d;
      out_en_q        <= out_en_d;
      out_valid_q     <= out_valid_d;
      state_q         <= state_d;
      hdr_len_q       <= hdr_len_d;
      byte_cnt_q      <= byte_cnt_d;
      frame_count_q   <= frame_count_d;
      len_err_count_q <= len_err_count_d;
      len_err_q       <= mismatch;
    end
  end

  assign in_ready         = in_ready_c;
  assign out_bytes        = out_data_q;
  assign out_byte_enables = out_en_q;
  assign out_data_valid   = out_valid_q;
  assign frame_count      = frame_count_q;
  assign len_err_count    = len_err_count_q;
  assign len_err          = len_err_q;

endmodule
